// File: rtl/tanh_segment_locator.sv
// tanh_segment_locator
// Binary search over the tanh half-X breakpoint table. The block finds j with
// table[j] <= |x| < table[j+1], clamping operands past the last breakpoint, and
// hands j, the in-segment offset, the segment width, the sign and the saturation
// flag to the interpolation stage. One operand is in flight at a time. Latency
// is fixed at PREP + MW SEARCH cycles + FETCH.
`timescale 1ns/1ps
module tanh_segment_locator #(
    parameter int xDW = 24,
    parameter int ML  = 275,
    parameter int MW  = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [xDW-1:0] in_x,
    output logic [MW-1:0]  tbl_idx,
    input  logic [xDW-1:0] tbl_lo,
    input  logic [xDW-1:0] tbl_hi,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MW-1:0]  out_j,
    output logic [xDW-1:0] out_dx,
    output logic [xDW-1:0] out_seg_w,
    output logic           out_sign,
    output logic           out_sat
);

    // One extra magnitude bit so that |most negative operand| does not wrap.
    localparam int AW = xDW + 1;
    localparam int IW = $clog2(MW + 1);

    localparam logic [MW-1:0] IDX_LAST  = MW'(ML);
    localparam logic [MW-1:0] IDX_TOP   = MW'(ML + 1);
    localparam logic [MW-1:0] IDX_FIRST = MW'(1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MW - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SEARCH,
        FETCH,
        DONE
    } state_t;

    typedef struct packed {
        logic [MW-1:0]  j;
        logic [xDW-1:0] dx;
        logic [xDW-1:0] seg_w;
        logic           sign;
        logic           sat;
    } result_t;

    state_t        state;
    result_t       res;
    logic [AW-1:0] a;
    logic          sign_r;
    logic          sat_r;
    logic [MW-1:0] lo;
    logic [MW-1:0] hi;
    logic [IW-1:0] iter;

    logic [AW-1:0] in_x_ext;
    logic [AW-1:0] x_abs;
    logic [AW-1:0] lo_ext;
    logic [AW-1:0] hi_ext;
    logic [MW-1:0] span;
    logic          wide;
    logic [MW-1:0] mid;
    logic          ge_lo;
    logic          ge_hi;

    assign out_j     = res.j;
    assign out_dx    = res.dx;
    assign out_seg_w = res.seg_w;
    assign out_sign  = res.sign;
    assign out_sat   = res.sat;

    // Operand magnitude, search midpoint and unsigned xDW+1-bit compares.
    always_comb begin
        in_x_ext = {in_x[xDW-1], in_x};
        x_abs    = in_x[xDW-1] ? (~in_x_ext + AW'(1)) : in_x_ext;
        lo_ext   = {1'b0, tbl_lo};
        hi_ext   = {1'b0, tbl_hi};
        span     = hi - lo;
        wide     = (span > MW'(1));
        mid      = MW'(({1'b0, lo} + {1'b0, hi}) >> 1);
        ge_lo    = (a >= lo_ext);
        ge_hi    = (a >= hi_ext);
    end

    // Table index: last segment in PREP (so tbl_hi is table[ML+1]), probe
    // midpoint while the window is still open, otherwise the resolved lo.
    always_comb begin
        tbl_idx = '0;
        case (state)
            PREP:    tbl_idx = IDX_LAST;
            SEARCH:  tbl_idx = wide ? mid : lo;
            FETCH:   tbl_idx = lo;
            default: tbl_idx = '0;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            a         <= '0;
            sign_r    <= 1'b0;
            sat_r     <= 1'b0;
            lo        <= '0;
            hi        <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a        <= x_abs;
                        sign_r   <= in_x[xDW-1];
                        in_ready <= 1'b0;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    // Past the last breakpoint: pin to the top of the last segment.
                    if (ge_hi) begin
                        sat_r <= 1'b1;
                        a     <= hi_ext - AW'(1);
                    end else begin
                        sat_r <= 1'b0;
                    end
                    lo    <= IDX_FIRST;
                    hi    <= IDX_TOP;
                    iter  <= '0;
                    state <= SEARCH;
                end
                SEARCH: begin
                    // Always MW iterations so latency is operand-independent;
                    // once the window is one segment wide lo/hi just hold.
                    if (wide) begin
                        if (ge_lo) lo <= mid;
                        else       hi <= mid;
                    end
                    iter <= iter + IW'(1);
                    if (iter == ITER_LAST) state <= FETCH;
                end
                FETCH: begin
                    res.j     <= lo;
                    res.dx    <= xDW'(a - lo_ext);
                    res.seg_w <= tbl_hi - tbl_lo;
                    res.sign  <= sign_r;
                    res.sat   <= sat_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_segment_locator.sv
// Bench for tanh_segment_locator: breakpoint table model driving tbl_lo/tbl_hi,
// table-driven known vectors, backpressure, mid-search reset, a sweep around
// every breakpoint and random operands against a linear-scan reference.
`timescale 1ns/1ps
module tb_tanh_segment_locator;

    localparam int XDW = 24;
    localparam int ML  = 275;
    localparam int MW  = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [XDW-1:0] in_x = '0;
    logic [MW-1:0]  tbl_idx;
    logic [XDW-1:0] tbl_lo;
    logic [XDW-1:0] tbl_hi;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [MW-1:0]  out_j;
    logic [XDW-1:0] out_dx;
    logic [XDW-1:0] out_seg_w;
    logic           out_sign;
    logic           out_sat;

    logic [XDW-1:0] tbl [0:ML+1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [XDW-1:0] x;
        logic [MW-1:0]  j;
        logic [XDW-1:0] dx;
        logic [XDW-1:0] w;
        logic           s;
        logic           sat;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    assign tbl_lo = tbl[int'(tbl_idx)];
    assign tbl_hi = tbl[int'(tbl_idx) + 1];

    tanh_segment_locator #(.xDW(XDW), .ML(ML), .MW(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .tbl_idx   (tbl_idx),
        .tbl_lo    (tbl_lo),
        .tbl_hi    (tbl_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_j     (out_j),
        .out_dx    (out_dx),
        .out_seg_w (out_seg_w),
        .out_sign  (out_sign),
        .out_sat   (out_sat)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: magnitude, clamp, then linear scan for the largest j with table[j] <= a.
    task automatic model(input logic [XDW-1:0] x, output logic [MW-1:0] j,
                         output logic [XDW-1:0] dx, output logic [XDW-1:0] w,
                         output logic s, output logic sat);
        longint a;
        int     jj;
        a   = longint'($signed(x));
        s   = (a < 0);
        if (a < 0) a = -a;
        sat = (a >= longint'(tbl[ML+1]));
        if (sat) a = longint'(tbl[ML+1]) - 1;
        jj = 1;
        for (int k = 1; k <= ML; k++)
            if (longint'(tbl[k]) <= a) jj = k;
        j  = MW'(jj);
        dx = XDW'(a - longint'(tbl[jj]));
        w  = tbl[jj+1] - tbl[jj];
    endtask

    // Drives one operand, measures accept-to-valid edges, captures the result
    // and completes the handshake. lat = -1 if the result never appeared.
    task automatic run_op(input logic [XDW-1:0] x, output int lat,
                          output logic [MW-1:0] j, output logic [XDW-1:0] dx,
                          output logic [XDW-1:0] w, output logic s, output logic sat);
        int k;
        lat = -1; j = '0; dx = '0; w = '0; s = 1'b0; sat = 1'b0;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_x     = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = XDW'($urandom);
        chk("in_ready_low_after_accept", longint'(in_ready), 0);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 40);
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        lat = k;
        j = out_j; dx = out_dx; w = out_seg_w; s = out_sign; sat = out_sat;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", longint'(in_ready), 1);
        chk("out_valid_drop", longint'(out_valid), 0);
    endtask

    task automatic check_vs(input string tag, input logic [XDW-1:0] x,
                            input logic [MW-1:0] ej, input logic [XDW-1:0] edx,
                            input logic [XDW-1:0] ew, input logic es, input logic esat);
        int lat;
        logic [MW-1:0] j;
        logic [XDW-1:0] dx, w;
        logic s, sat;
        run_op(x, lat, j, dx, w, s, sat);
        if (lat < 0) return;
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_j"},   longint'(j),   longint'(ej));
        chk({tag, "_dx"},  longint'(dx),  longint'(edx));
        chk({tag, "_w"},   longint'(w),   longint'(ew));
        chk({tag, "_sign"}, longint'(s),  longint'(es));
        chk({tag, "_sat"}, longint'(sat), longint'(esat));
    endtask

    task automatic check_model(input string tag, input logic [XDW-1:0] x);
        logic [MW-1:0] ej;
        logic [XDW-1:0] edx, ew;
        logic es, esat;
        model(x, ej, edx, ew, es, esat);
        check_vs(tag, x, ej, edx, ew, es, esat);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XDW-1:0] hold_dx, hold_w, xr;
        logic [MW-1:0]  hold_j;
        int             cnt, k;

        // Monotone table matching the known-answer vectors below.
        for (int j = 0; j <= ML + 1; j++) begin
            if (j <= 1)        tbl[j] = '0;
            else if (j <= 11)  tbl[j] = XDW'(32'h100 * j);
            else if (j <= 181) tbl[j] = XDW'(32'hB80 + 32'h80 * (j - 12));
            else if (j <= 274) tbl[j] = XDW'(32'h6000 + 32'h100 * (j - 181));
            else if (j == 275) tbl[j] = 24'h020000;
            else               tbl[j] = 24'h040000;
        end

        vecs[0] = '{24'h000000, 9'd1,   24'h000000, 24'h000200, 1'b0, 1'b0};
        vecs[1] = '{24'h000250, 9'd2,   24'h000050, 24'h000100, 1'b0, 1'b0};
        vecs[2] = '{24'h006080, 9'd181, 24'h000080, 24'h000100, 1'b0, 1'b0};
        vecs[3] = '{24'hFFF480, 9'd12,  24'h000000, 24'h000080, 1'b1, 1'b0};
        vecs[4] = '{24'h050000, 9'd275, 24'h01FFFF, 24'h020000, 1'b0, 1'b1};
        vecs[5] = '{24'h800000, 9'd275, 24'h01FFFF, 24'h020000, 1'b1, 1'b1};
        vecs[6] = '{24'h03FFFF, 9'd275, 24'h01FFFF, 24'h020000, 1'b0, 1'b0};
        vecs[7] = '{24'hFFFFFF, 9'd1,   24'h000001, 24'h000200, 1'b1, 1'b0};

        // Reset state.
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  longint'(in_ready),  0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_j",     longint'(out_j),     0);
        chk("rst_out_dx",    longint'(out_dx),    0);
        chk("rst_out_w",     longint'(out_seg_w), 0);
        chk("rst_sign_sat",  longint'({out_sign, out_sat}), 0);
        chk("rst_tbl_idx",   longint'(tbl_idx),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_rise", longint'(in_ready), 1);

        // Known-answer vectors.
        foreach (vecs[i])
            check_vs($sformatf("vec%0d", i), vecs[i].x, vecs[i].j, vecs[i].dx,
                     vecs[i].w, vecs[i].s, vecs[i].sat);

        // Backpressure: result must hold and the input side stay closed.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 24'h006080;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 40);
        chk("bp_latency", k, 11);
        hold_j = out_j; hold_dx = out_dx; hold_w = out_seg_w;
        chk("bp_j", longint'(hold_j), 181);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", longint'(out_valid), 1);
            chk("bp_in_ready_low", longint'(in_ready), 0);
            chk("bp_outputs_stable", longint'({out_j, out_dx, out_seg_w}),
                longint'({hold_j, hold_dx, hold_w}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", longint'(in_ready), 1);
        chk("bp_release_valid", longint'(out_valid), 0);

        // Reset in the middle of the search (outputs still hold j=181).
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 24'h000250;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_j",   longint'(out_j),     0);
        chk("midrst_out_dx",  longint'(out_dx),    0);
        chk("midrst_out_w",   longint'(out_seg_w), 0);
        chk("midrst_valid",   longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_tbl_idx", longint'(tbl_idx),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("midrst_no_result", cnt, 0);
        check_vs("post_rst", 24'hFFF480, 9'd12, 24'h000000, 24'h000080, 1'b1, 1'b0);

        // Sweep every breakpoint and its neighbours, random sign.
        for (int kk = 1; kk <= ML + 1; kk++) begin
            for (int d = -1; d <= 1; d++) begin
                longint v;
                v = longint'(tbl[kk]) + d;
                if (v < 0) continue;
                xr = XDW'(v);
                if ($urandom_range(1, 0) == 1) xr = -xr;
                check_model($sformatf("sweep_k%0d_d%0d", kk, d), xr);
            end
        end

        // Random operands: mostly in-table magnitudes, some full-range.
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(3, 0) == 0) xr = XDW'($urandom);
            else begin
                xr = XDW'($urandom_range(32'h48000, 0));
                if ($urandom_range(1, 0) == 1) xr = -xr;
            end
            check_model($sformatf("rand%0d_x%0h", r, xr), xr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
